// File: rtl/cs_thr_pkg.sv
// Shared encodings and width helpers for the compressed-sensing adaptive thresholder.
// Mode and state enums are used by the top; sum width helper by the window averager.
package cs_thr_pkg;

  typedef enum logic [1:0] {
    MODE_POS = 2'b00,
    MODE_NEG = 2'b01,
    MODE_ABS = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DW       = 12;
  localparam int DEF_WIN_LOG2 = 4;
  localparam int DEF_SUM_W    = DEF_DW + 1 + DEF_WIN_LOG2;

  // Running sum over 2^win_log2 signed (dw+1)-bit centred samples never overflows this width.
  function automatic int sum_width(input int dw, input int win_log2);
    return dw + 1 + win_log2;
  endfunction

  // Threshold comparisons need one extra bit beyond the centred sample for avg +/- thr.
  function automatic int cmp_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/window_avg.sv
// Sliding-window mean of signed samples: shift register plus running sum, avg = floor(sum / 2^WIN_LOG2).
// avg reflects the window before the sample pushed this cycle; push has no backpressure of its own.
module window_avg
  import cs_thr_pkg::*;
#(
  parameter int W        = 13,
  parameter int WIN_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                push,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] avg
);

  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = sum_width(W - 1, WIN_LOG2);

  logic signed [W-1:0]  win_q [N];
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] din_x;
  logic signed [SW-1:0] old_x;

  assign din_x = {{WIN_LOG2{din[W-1]}}, din};
  assign old_x = {{WIN_LOG2{win_q[N-1][W-1]}}, win_q[N-1]};
  assign sum_d = sum_q + din_x - old_x;

  // Dropping the low WIN_LOG2 bits of a two's-complement sum is an arithmetic floor shift.
  assign avg = sum_q[SW-1:WIN_LOG2];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum_q <= '0;
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
    end else if (push) begin
      sum_q    <= sum_d;
      win_q[0] <= din;
      for (int i = 1; i < N; i++) begin
        win_q[i] <= win_q[i-1];
      end
    end
  end

endmodule

// File: rtl/adaptive_threshold.sv
// Streaming sparsifier: removes DC mean, forwards samples clearing window-average +/- thresh, else zero.
// One cycle input-to-output latency; s_ready drops while the output register is stalled.
module adaptive_threshold
  import cs_thr_pkg::*;
#(
  parameter int DW        = 12,
  parameter int WIN_LOG2  = 4,
  parameter int FRAME_LEN = 2048,
  parameter int IDW       = 11,
  parameter int MEAN      = 958
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DW-1:0]       thresh,
  input  logic                s_valid,
  input  logic [DW-1:0]       s_data,
  output logic                s_ready,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [DW:0]  m_data,
  output logic [IDW-1:0]      m_idx,
  output logic                m_last,
  output logic                busy,
  output logic                frame_done,
  output logic [IDW:0]        nz_count
);

  localparam int                CW       = cmp_width(DW);
  localparam logic signed [DW:0] MEAN_S  = (DW+1)'(MEAN);
  localparam logic [IDW-1:0]    LAST_IDX = IDW'(FRAME_LEN - 1);

  state_e               state_q;
  mode_e                mode_q;
  logic [DW-1:0]        thr_q;
  logic [IDW-1:0]       idx_q;
  logic [IDW-1:0]       idx_d;
  logic [IDW:0]         nz_q;
  logic [IDW:0]         nz_d;
  logic                 m_valid_q;
  logic signed [DW:0]   m_data_q;
  logic [IDW-1:0]       m_idx_q;
  logic                 m_last_q;
  logic                 frame_done_q;

  logic signed [DW:0]   d;
  logic signed [DW:0]   avg;
  logic signed [DW:0]   out_d;
  logic signed [CW-1:0] d_x;
  logic signed [CW-1:0] avg_x;
  logic signed [CW-1:0] thr_x;
  logic signed [CW-1:0] hi_lim;
  logic signed [CW-1:0] lo_lim;
  logic                 pos_ok;
  logic                 neg_ok;
  logic                 pass;
  logic                 accept;
  logic                 out_hs;
  logic                 win_clear;
  logic                 rdy;

  assign d = $signed({1'b0, s_data}) - MEAN_S;

  // Once the last beat is registered no further sample may enter until the next start.
  assign rdy    = (state_q == ST_RUN) && !(m_valid_q && m_last_q) && (!m_valid_q || m_ready);
  assign accept = s_valid && rdy;
  assign out_hs = m_valid_q && m_ready;

  assign win_clear = (state_q == ST_IDLE) && start;

  window_avg #(
    .W        (DW + 1),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window_avg (
    .clk   (clk),
    .reset (reset),
    .clear (win_clear),
    .push  (accept),
    .din   (d),
    .avg   (avg)
  );

  assign d_x    = {d[DW], d};
  assign avg_x  = {avg[DW], avg};
  assign thr_x  = {2'b00, thr_q};
  assign hi_lim = avg_x + thr_x;
  assign lo_lim = avg_x - thr_x;
  assign pos_ok = (d_x >= hi_lim);
  assign neg_ok = (d_x <= lo_lim);

  always_comb begin
    pass = 1'b0;
    case (mode_q)
      MODE_POS: pass = pos_ok;
      MODE_NEG: pass = neg_ok;
      MODE_ABS: pass = pos_ok || neg_ok;
      MODE_BYP: pass = 1'b1;
      default:  pass = 1'b0;
    endcase
  end

  assign out_d = pass ? d : '0;
  assign idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDW'(1);
  assign nz_d  = nz_q + (IDW+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_POS;
      thr_q        <= '0;
      idx_q        <= '0;
      nz_q         <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_idx_q      <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            mode_q  <= mode_e'(mode);
            thr_q   <= thresh;
            idx_q   <= '0;
            nz_q    <= '0;
          end
        end
        ST_RUN: begin
          if (out_hs) begin
            m_valid_q <= 1'b0;
            if (m_last_q) begin
              state_q      <= ST_IDLE;
              frame_done_q <= 1'b1;
            end
          end
          // A new accept in the same cycle as a drain overrides the clear of m_valid_q.
          if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= out_d;
            m_idx_q   <= idx_q;
            m_last_q  <= (idx_q == LAST_IDX);
            idx_q     <= idx_d;
            if (out_d != '0) begin
              nz_q <= nz_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = rdy;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_idx      = m_idx_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q == ST_RUN);
  assign frame_done = frame_done_q;
  assign nz_count   = nz_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Scoreboard bench for adaptive_threshold with FRAME_LEN=16, WIN_LOG2=4, MEAN=958.
module tb_adaptive_threshold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start;
  logic [1:0]         mode;
  logic [11:0]        thresh;
  logic               s_valid;
  logic [11:0]        s_data;
  logic               s_ready;
  logic               m_valid;
  logic               m_ready;
  logic signed [12:0] m_data;
  logic [3:0]         m_idx;
  logic               m_last;
  logic               busy;
  logic               frame_done;
  logic [4:0]         nz_count;

  adaptive_threshold #(
    .DW        (12),
    .WIN_LOG2  (4),
    .FRAME_LEN (16),
    .IDW       (4),
    .MEAN      (958)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .thresh     (thresh),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_idx      (m_idx),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
    .nz_count   (nz_count)
  );

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   fd_exp = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: pops one expectation per output handshake; frame_done must follow the last beat.
  always @(negedge clk) begin
    if (reset) begin
      fd_exp = 1'b0;
    end else begin
      if (fd_exp || frame_done) check("frame_done", frame_done, fd_exp);
      fd_exp = 1'b0;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got idx %0d data %0d expected no output", m_idx, m_data);
        end else begin
          mon_e = sb.pop_front();
          check("m_data", int'(m_data), mon_e.data);
          check("m_idx", int'(m_idx), mon_e.idx);
          check("m_last", int'(m_last), int'(mon_e.last));
          fd_exp = m_last;
        end
      end
    end
  end

  task automatic push_exp(input int data, input int idx);
    sb.push_back('{data: data, idx: idx, last: (idx == 15)});
  endtask

  task automatic send(input logic [11:0] v);
    int  n;
    bit  done;
    n       = 0;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = v;
    while (!done) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        fail_now("send");
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] md, input logic [11:0] th);
    start  = 1'b1;
    mode   = md;
    thresh = th;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_frame(input int exp_nz);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("wait_frame");
    check("nz_count", int'(nz_count), exp_nz);
    check("s_ready_idle", s_ready, 0);
    @(posedge clk);
    #1;
  endtask

  // Every non-spike sample is 958 (d=0); with thresh 84 those never pass in these frames.
  task automatic run_frame(input logic [1:0] md, input logic [11:0] th, input int sp_idx,
                           input logic [11:0] sp_val, input int sp_exp, input int exp_nz);
    start_frame(md, th);
    for (int i = 0; i < 16; i++) begin
      push_exp((i == sp_idx) ? sp_exp : 0, i);
      send((i == sp_idx) ? sp_val : 12'd958);
    end
    wait_frame(exp_nz);
  endtask

  logic [11:0] byp_in  [16] = '{12'd0, 12'd958, 12'd4095, 12'd100, 12'd1000, 12'd900, 12'd2000, 12'd50,
                                12'd958, 12'd1500, 12'd3000, 12'd957, 12'd959, 12'd12, 12'd2500, 12'd700};
  int          byp_exp [16] = '{-958, 0, 3137, -858, 42, -58, 1042, -908,
                                0, 542, 2042, -1, 1, -946, 1542, -258};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    thresh  = 12'd0;
    s_valid = 1'b0;
    s_data  = 12'd0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_idx", int'(m_idx), 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_nz_count", int'(nz_count), 0);
    check("rst_s_ready", s_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_frame(2'b00, 12'd84, 0, 12'd958,  0,    0);
    run_frame(2'b00, 12'd84, 3, 12'd1158, 200,  1);
    run_frame(2'b00, 12'd84, 0, 12'd1042, 84,   1);
    run_frame(2'b00, 12'd84, 0, 12'd1041, 0,    0);
    run_frame(2'b01, 12'd84, 0, 12'd758,  -200, 1);
    run_frame(2'b01, 12'd84, 0, 12'd1158, 0,    0);
    run_frame(2'b10, 12'd84, 0, 12'd1158, 200,  1);
    run_frame(2'b10, 12'd84, 0, 12'd758,  -200, 1);

    // Bypass, with a stray start and new mode/thresh mid-frame that must be ignored.
    start_frame(2'b11, 12'd4095);
    for (int i = 0; i < 16; i++) begin
      push_exp(byp_exp[i], i);
      if (i == 5) begin
        start  = 1'b1;
        mode   = 2'b00;
        thresh = 12'd0;
      end
      send(byp_in[i]);
      start = 1'b0;
    end
    wait_frame(14);

    // Output stall of 5 cycles while input stays valid.
    start_frame(2'b00, 12'd84);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          push_exp((i == 3) ? 200 : 0, i);
          send((i == 3) ? 12'd1158 : 12'd958);
        end
      end
      begin
        int cap_d;
        int cap_i;
        repeat (6) @(posedge clk);
        #1;
        m_ready = 1'b0;
        cap_d   = 0;
        cap_i   = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_s_ready", s_ready, 0);
          check("stall_m_valid", m_valid, 1);
          if (k == 0) begin
            cap_d = int'(m_data);
            cap_i = int'(m_idx);
          end else begin
            check("stall_m_data", int'(m_data), cap_d);
            check("stall_m_idx", int'(m_idx), cap_i);
          end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_frame(1);

    // Reset after idx 7 is accepted; its output must never appear.
    start_frame(2'b00, 12'd84);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) push_exp(200, i);
      send(12'd1158);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_nz", int'(nz_count), 0);
    check("rst_mid_s_ready", s_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_queue", sb.size(), 0);
    run_frame(2'b00, 12'd84, 0, 12'd1042, 84, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
